regfile_2r1w_sync: RTL and testbench
====================================

# regfile_2r1w_sync

Parametrised two-read/one-write register file with registered (synchronous) read ports, an automatic post-reset clear sequencer and optional write-to-read forwarding. It is the datapath register file for the CPU core and replaces the fixed 16×16 asynchronous-read version. Storage maps onto block RAM, so clearing is done by a sequencer rather than a one-cycle array reset.

## Interface
- WIDTH, 16, data width of each register
- REGBITS, 4, address width; DEPTH = 2**REGBITS registers
- ZERO_REG, 0, when 1 register 0 is hardwired to zero
- clk  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- writeEn  in  1  write strobe, qualified by ready
- writeData  in  WIDTH  data written to register dstAddr
- dstAddr  in  REGBITS  write address and read address for port 1
- srcAddr  in  REGBITS  read address for port 2
- readData1  out  WIDTH  registered contents of dstAddr
- readData2  out  WIDTH  registered contents of srcAddr
- ready  out  1  high once the clear sequence has finished

## Operation
- States: CLEAR, RUN.
- Reset high at an edge: state<=CLEAR, clear index<=0, ready<=0, readData1<=0, readData2<=0.
- CLEAR, reset low: at each edge write 0 to register[index], index<=index+1; on the edge that writes DEPTH-1, state<=RUN and ready<=1.
- While in CLEAR: writeEn ignored, readData1/readData2 held at 0.
- RUN: if writeEn, register[dstAddr]<=writeData at the edge. Both read ports sample their addresses each edge.
- ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0 on either port regardless of forwarding.
- Both ports reading the same address return identical data.
- Reset asserted mid-CLEAR or mid-RUN: restart from CLEAR, index 0; array contents are not guaranteed until ready rises again.
- No arithmetic; index counter is REGBITS+1 bits or terminal-compared so wrap never skips RUN entry.

## Timing
- Read latency 1: address applied before edge N -> data valid on readDataX after edge N.
- Write visible through the array from edge N+1 onward (read sampled at edge N+1 returns new value).
- Same-edge write and read of the same address: behaviour set by Configuration.
- ready rises after the DEPTH-th rising edge with reset low (16 edges for REGBITS=4); first accepted write is at the edge after ready is seen high.
- ready stays high until the next reset.

## Configuration
- REGFILE_BYPASS_EN defined: write-first. If writeEn and dstAddr equals a port's read address at edge N, that port outputs writeData after edge N (port 1 always matches on a write, since it shares dstAddr).
- Undefined: read-first. The port outputs the previous contents after edge N; new value appears after edge N+1.
- ZERO_REG masking takes precedence over forwarding in both builds.

## Structure
- Package regfile_pkg: state enum {CLEAR, RUN}, default WIDTH/REGBITS constants.
- Sub-module regfile_clear_seq: CLEAR/RUN FSM and index counter; outputs clear write enable, clear address, ready. Top muxes clear vs. user write port into the array.

## Test plan
- Reset 2 cycles then release -> ready low for 15 edges, high after 16th; read every register -> all 0.
- After ready: write 16'd2 to reg 1 at edge N, read reg 1 on port 1 at edge N+1 -> 16'h0002 after N+1.
- Write 16'hBEEF to reg 5 while srcAddr=5 at same edge -> readData2=16'hBEEF after that edge with REGFILE_BYPASS_EN, old value (0) without it and 16'hBEEF one edge later.
- ZERO_REG=1: write 16'hFFFF to reg 0, read on both ports -> 0; with ZERO_REG=0 -> 16'hFFFF.
- Fill reg 3 with 16'h1234, assert reset mid-CLEAR (after 8 edges), release -> ready rises 16 edges after release, reg 3 reads 0.
- writeEn high during CLEAR with dstAddr=7, data 16'hAAAA -> ignored; reg 7 reads 0 after ready.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the two-read/one-write register file.
//   state_t      : sequencer state, CLEAR while the array is being zeroed,
//                  RUN once user traffic is accepted
//   DEF_WIDTH    : default register width
//   DEF_REGBITS  : default address width (DEPTH = 2**REGBITS)
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_REGBITS = 4;

endpackage

// File: rtl/regfile_2r1w_sync_if.sv
// Bus bundle for regfile_2r1w_sync.
//   writeEn    : write strobe, only honoured once ready is high
//   writeData  : data written to dstAddr
//   dstAddr    : write address, also the read address of port 1
//   srcAddr    : read address of port 2
//   readData1  : registered contents of dstAddr
//   readData2  : registered contents of srcAddr
//   ready      : high once the post-reset clear sequence has finished
// Modports: master drives requests (CPU / testbench), slave is the register file.
interface regfile_2r1w_sync_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) ();

  logic               writeEn;
  logic [WIDTH-1:0]   writeData;
  logic [REGBITS-1:0] dstAddr;
  logic [REGBITS-1:0] srcAddr;
  logic [WIDTH-1:0]   readData1;
  logic [WIDTH-1:0]   readData2;
  logic               ready;

  modport master (
    output writeEn, writeData, dstAddr, srcAddr,
    input  readData1, readData2, ready
  );

  modport slave (
    input  writeEn, writeData, dstAddr, srcAddr,
    output readData1, readData2, ready
  );

endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer for the register file.
// Walks an index over every register address once after reset, requesting a
// zero write at each, then switches to RUN and raises ready.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr_we     : high while the array should be written with zero
//   clr_addr   : register address being cleared this cycle
//   ready      : high in RUN, stays high until the next reset
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int REGBITS = DEF_REGBITS
) (
  input  logic               clk,
  input  logic               reset,
  output logic               clr_we,
  output logic [REGBITS-1:0] clr_addr,
  output logic               ready
);

  // Terminal compare against the last address, so the counter may wrap
  // freely without ever skipping RUN entry.
  localparam logic [REGBITS-1:0] LAST_IDX = '1;

  state_t             state, state_nxt;
  logic [REGBITS-1:0] idx, idx_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      CLEAR: begin
        idx_nxt = idx + REGBITS'(1);
        if (idx == LAST_IDX) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = CLEAR;
    endcase
  end

  always_comb begin
    clr_we   = (state == CLEAR);
    clr_addr = idx;
    ready    = (state == RUN);
  end

endmodule

// File: rtl/regfile_2r1w_sync.sv
// Two-read/one-write register file with registered read ports.
// The storage array has no reset so it maps onto block RAM; after reset a
// sequencer zeroes every entry before ready rises and user writes are taken.
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous active-high reset, restarts the clear sequence
//   bus   : regfile_2r1w_sync_if slave modport (write port, two read ports,
//           ready)
// Parameters:
//   WIDTH    : register width
//   REGBITS  : address width, DEPTH = 2**REGBITS
//   ZERO_REG : 1 hardwires register 0 to zero
// Build option:
//   REGFILE_BYPASS_EN defined   -> write-first: a same-edge write to a read
//                                  address is forwarded to that read port.
//   REGFILE_BYPASS_EN undefined -> read-first: the port returns the old value.
module regfile_2r1w_sync
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REGBITS  = DEF_REGBITS,
  parameter int ZERO_REG = 0
) (
  input logic                clk,
  input logic                reset,
  regfile_2r1w_sync_if.slave bus
);

  localparam int DEPTH = 2 ** REGBITS;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic               clr_we;
  logic [REGBITS-1:0] clr_addr;
  logic               seq_ready;

  logic               arr_we;
  logic [REGBITS-1:0] arr_addr;
  logic [WIDTH-1:0]   arr_data;
  logic               user_we;

  logic [WIDTH-1:0]   rd1_p1;
  logic [WIDTH-1:0]   rd2_p1;

  regfile_clear_seq #(
    .REGBITS (REGBITS)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (seq_ready)
  );

  function automatic logic is_zero_reg(input logic [REGBITS-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  // Read-port value: zero masking first, then optional forwarding, then the
  // array contents.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic [REGBITS-1:0] addr,
    input logic [WIDTH-1:0]   stored
  );
    if (is_zero_reg(addr)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (user_we && (addr == bus.dstAddr)) return bus.writeData;
`endif
    return stored;
  endfunction

  // User writes only count in RUN; writes to a hardwired zero register are
  // dropped so the array itself also stays zero there.
  assign user_we = seq_ready && bus.writeEn && !is_zero_reg(bus.dstAddr);

  always_comb begin
    arr_we   = 1'b0;
    arr_addr = bus.dstAddr;
    arr_data = bus.writeData;
    if (!reset) begin
      if (clr_we) begin
        arr_we   = 1'b1;
        arr_addr = clr_addr;
        arr_data = '0;
      end else if (user_we) begin
        arr_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) mem[arr_addr] <= arr_data;
  end

  // ---- read stage p1: registered read ports ----
  always_ff @(posedge clk) begin
    if (reset || !seq_ready) begin
      rd1_p1 <= '0;
      rd2_p1 <= '0;
    end else begin
      rd1_p1 <= read_sel(bus.dstAddr, mem[bus.dstAddr]);
      rd2_p1 <= read_sel(bus.srcAddr, mem[bus.srcAddr]);
    end
  end

  assign bus.readData1 = rd1_p1;
  assign bus.readData2 = rd2_p1;
  assign bus.ready     = seq_ready;

endmodule

// File: tb/tb_regfile_2r1w_sync.sv
// Bench for regfile_2r1w_sync: one instance with ZERO_REG=0 (index 0) and one
// with ZERO_REG=1 (index 1) share the same stimulus; a behavioural model of
// both register files supplies every expected value.
module tb_regfile_2r1w_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] wd;
  logic [3:0]  da;
  logic [3:0]  sa;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_2r1w_sync_if #(.WIDTH(16), .REGBITS(4)) bus0 ();
  regfile_2r1w_sync_if #(.WIDTH(16), .REGBITS(4)) bus1 ();

  assign bus0.writeEn = we;  assign bus1.writeEn = we;
  assign bus0.writeData = wd; assign bus1.writeData = wd;
  assign bus0.dstAddr = da;  assign bus1.dstAddr = da;
  assign bus0.srcAddr = sa;  assign bus1.srcAddr = sa;

  regfile_2r1w_sync #(.WIDTH(16), .REGBITS(4), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0));
  regfile_2r1w_sync #(.WIDTH(16), .REGBITS(4), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset(rst), .bus(bus1));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [15:0] m [2][16];
  int          cleared = 0;
  logic [15:0] e_rd1 [2];
  logic [15:0] e_rd2 [2];
  logic        e_ready = 1'b0;

  function automatic logic [15:0] model_read(int k, logic [3:0] a);
    if (k == 1 && a == 4'd0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (we && a == da) return wd;
`endif
    return m[k][a];
  endfunction

  function automatic logic [15:0] get_rd1(int k);
    return (k == 0) ? bus0.readData1 : bus1.readData1;
  endfunction
  function automatic logic [15:0] get_rd2(int k);
    return (k == 0) ? bus0.readData2 : bus1.readData2;
  endfunction
  function automatic logic get_ready(int k);
    return (k == 0) ? bus0.ready : bus1.ready;
  endfunction

  // Advance one rising edge, updating the model from the inputs in place.
  task automatic cycle();
    if (rst) begin
      cleared = 0;
      for (int k = 0; k < 2; k++) begin e_rd1[k] = '0; e_rd2[k] = '0; end
    end else if (cleared < 16) begin
      for (int k = 0; k < 2; k++) begin
        m[k][cleared] = '0;
        e_rd1[k] = '0;
        e_rd2[k] = '0;
      end
      cleared++;
    end else begin
      for (int k = 0; k < 2; k++) begin
        e_rd1[k] = model_read(k, da);
        e_rd2[k] = model_read(k, sa);
      end
      if (we) begin
        m[0][da] = wd;
        if (da != 4'd0) m[1][da] = wd;
      end
    end
    e_ready = (cleared == 16);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wd = '0; da = '0; sa = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    cycle(); cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_ready(k) !== 1'b0 || get_rd1(k) !== 16'h0 || get_rd2(k) !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: ready=%b rd1=%h rd2=%h, required ready=0 rd1=0 rd2=0",
                 k, get_ready(k), get_rd1(k), get_rd2(k));
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      cycle();
      n_checks++;
      if (bus0.ready !== (e == 16)) begin
        n_fail++;
        $display("FAIL ready_rise edge %0d: ready=%b required %b", e, bus0.ready, (e == 16));
      end
    end
    for (int a = 0; a < 16; a++) begin
      da = 4'(a); sa = 4'(15 - a);
      cycle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (get_rd1(k) !== 16'h0 || get_rd2(k) !== 16'h0) begin
          n_fail++;
          $display("FAIL cleared_read dut%0d addr %0d: rd1=%h rd2=%h required 0000 0000",
                   k, a, get_rd1(k), get_rd2(k));
        end
      end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; da = 4'd1; wd = 16'd2; sa = 4'd2;
    cycle();
    we = 1'b0; da = 4'd1; sa = 4'd1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (get_rd1(k) !== 16'h0002 || get_rd2(k) !== 16'h0002) begin
        n_fail++;
        $display("FAIL write_read dut%0d: rd1=%h rd2=%h required 0002 0002",
                 k, get_rd1(k), get_rd2(k));
      end
    end
  endtask

  task automatic test_same_edge();
    logic [15:0] exp_now;
`ifdef REGFILE_BYPASS_EN
    exp_now = 16'hBEEF;
`else
    exp_now = 16'h0000;
`endif
    we = 1'b1; da = 4'd5; wd = 16'hBEEF; sa = 4'd5;
    cycle();
    n_checks++;
    if (bus0.readData2 !== exp_now || bus0.readData1 !== exp_now) begin
      n_fail++;
      $display("FAIL same_edge: rd1=%h rd2=%h required %h", bus0.readData1, bus0.readData2, exp_now);
    end
    we = 1'b0;
    cycle();
    n_checks++;
    if (bus0.readData2 !== 16'hBEEF || bus1.readData2 !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL same_edge_next: rd2 dut0=%h dut1=%h required beef", bus0.readData2, bus1.readData2);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; da = 4'd0; wd = 16'hFFFF; sa = 4'd0;
    cycle();
    n_checks++;
    if (bus1.readData1 !== 16'h0 || bus1.readData2 !== 16'h0 ||
        bus0.readData2 !== e_rd2[0]) begin
      n_fail++;
      $display("FAIL zero_reg_write_edge: dut1 rd1=%h rd2=%h dut0 rd2=%h, required 0000 0000 %h",
               bus1.readData1, bus1.readData2, bus0.readData2, e_rd2[0]);
    end
    we = 1'b0;
    cycle();
    n_checks++;
    if (bus1.readData1 !== 16'h0 || bus1.readData2 !== 16'h0) begin
      n_fail++;
      $display("FAIL zero_reg_on: rd1=%h rd2=%h required 0000 0000", bus1.readData1, bus1.readData2);
    end
    n_checks++;
    if (bus0.readData1 !== 16'hFFFF || bus0.readData2 !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL zero_reg_off: rd1=%h rd2=%h required ffff ffff", bus0.readData1, bus0.readData2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 99) < 60);
      wd = 16'($urandom);
      da = 4'($urandom_range(0, 15));
      sa = ($urandom_range(0, 3) == 0) ? da : 4'($urandom_range(0, 15));
      cycle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (get_rd1(k) !== e_rd1[k] || get_rd2(k) !== e_rd2[k] || get_ready(k) !== e_ready) begin
          n_fail++;
          $display("FAIL random dut%0d iter %0d: rd1=%h rd2=%h ready=%b required %h %h %b",
                   k, i, get_rd1(k), get_rd2(k), get_ready(k), e_rd1[k], e_rd2[k], e_ready);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    int edges;
    we = 1'b1; da = 4'd3; wd = 16'h1234;
    cycle();
    we = 1'b0; sa = 4'd3;
    cycle();
    n_checks++;
    if (bus0.readData2 !== 16'h1234) begin
      n_fail++;
      $display("FAIL pre_reset_fill: rd2=%h required 1234", bus0.readData2);
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int e = 0; e < 8; e++) cycle();
    n_checks++;
    if (bus0.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_clear_ready: ready=%b required 0", bus0.ready);
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    edges = 0;
    while (bus0.ready !== 1'b1 && edges < 40) begin
      cycle();
      edges++;
    end
    n_checks++;
    if (edges != 16) begin
      n_fail++;
      $display("FAIL reclear_latency: ready after %0d edges required 16", edges);
    end
    da = 4'd3; sa = 4'd3;
    cycle();
    n_checks++;
    if (bus0.readData1 !== 16'h0 || bus0.readData2 !== 16'h0) begin
      n_fail++;
      $display("FAIL reclear_reg3: rd1=%h rd2=%h required 0000 0000", bus0.readData1, bus0.readData2);
    end
  endtask

  task automatic test_write_during_clear();
    rst = 1'b1; cycle(); rst = 1'b0;
    we = 1'b1; da = 4'd7; wd = 16'hAAAA; sa = 4'd7;
    for (int e = 0; e < 16; e++) begin
      cycle();
      n_checks++;
      if (bus0.readData1 !== 16'h0 || bus0.readData2 !== 16'h0) begin
        n_fail++;
        $display("FAIL clear_hold edge %0d: rd1=%h rd2=%h required 0000 0000",
                 e, bus0.readData1, bus0.readData2);
      end
    end
    we = 1'b0;
    cycle();
    n_checks++;
    if (bus0.readData1 !== 16'h0 || bus1.readData2 !== 16'h0) begin
      n_fail++;
      $display("FAIL clear_write_ignored: dut0 rd1=%h dut1 rd2=%h required 0000 0000",
               bus0.readData1, bus1.readData2);
    end
    n_checks++;
    if (bus0.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_hold: ready=%b required 1", bus0.ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_same_edge();
    test_zero_reg();
    test_random();
    test_reset_mid_clear();
    test_write_during_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
